cla_serial_ctrl: RTL and testbench
==================================

CLA_SERIAL_CTRL -- requirements
Module: cla_serial_ctrl

Interface
REQ-001 The block SHALL have parameter nBITS, default 16, giving the operand width in bits, restricted to a multiple of 4 and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have the request-side ports in_valid (input, 1 bit: request present) and in_ready (output, 1 bit: request accepted this cycle).
REQ-005 The block SHALL have the operand ports ain and bin (input, nBITS each) and cin (input, 1 bit: carry-in).
REQ-006 The block SHALL have the result-side ports out_valid (output, 1 bit: result held) and out_ready (input, 1 bit: consumer takes result).
REQ-007 The block SHALL have the result ports sum (output, nBITS) and cout (output, 1 bit).
REQ-008 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-009 The block SHALL compute {cout,sum} = ain + bin + cin by reusing one 4-bit CLA slice for NSLICE = nBITS/4 successive nibbles, least-significant nibble first.
REQ-010 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-011 In IDLE, in_ready SHALL be 1; in ADD and DONE, in_ready SHALL be 0.
REQ-012 On in_valid && in_ready, the block SHALL register ain, bin and cin, clear the slice index to 0, and enter ADD.
REQ-013 Each cycle in ADD, the block SHALL add nibble k of the registered operands plus the carry register, write the result into sum[4k+3:4k], load the slice carry-out into the carry register, and increment k.
REQ-014 When k = NSLICE-1 in ADD, the block SHALL enter DONE on that edge and load cout from the final slice carry-out.
REQ-015 out_valid SHALL be 1 only in DONE, asserting at the NSLICE-th rising edge after the accepting edge (4 edges for nBITS=16).
REQ-016 While out_valid=1 and out_ready=0, sum and cout SHALL be held stable.
REQ-017 On out_valid && out_ready, the block SHALL return to IDLE.
REQ-018 A new request SHALL be accepted no earlier than the cycle after the return to IDLE (no DONE-to-ADD bypass).
REQ-019 in_valid SHALL be ignored outside IDLE, and the operand inputs SHALL be ignored except at the accepting edge.
REQ-020 sum and cout SHALL retain the last result in IDLE until the next accept, and partial nibbles SHALL be visible on sum during ADD.
REQ-021 An illegal nBITS value SHALL cause an elaboration-time error.

Reset
REQ-022 While rst_n=0, the block SHALL asynchronously force the state to IDLE and set k, the carry register, sum, cout, out_valid and busy to 0, and in_ready to 1.
REQ-023 Reset asserted mid-ADD or mid-DONE SHALL abort the operation with no result delivered.
REQ-024 After rst_n is released, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-025 With macro CLA_SERIAL_OVF_EN defined, the block SHALL add output ovf (1 bit): signed two's-complement overflow, = (ain[MSB]==bin[MSB]) && (sum[MSB]!=ain[MSB]), registered with cout, reset 0, and valid with out_valid.
REQ-026 Without CLA_SERIAL_OVF_EN defined, the block SHALL have no ovf port and no overflow logic.

Structure
REQ-027 Package cla_pkg SHALL hold the state enum type (IDLE/ADD/DONE) and constant NIBBLE = 4.
REQ-028 The block SHALL instantiate one sub-module, cla4_slice, a combinational 4-bit carry lookahead adder with ports a, b, ci, s, co.
REQ-029 The slice index width SHALL be $clog2(NSLICE), with a minimum of 1 bit.

Verification
REQ-030 With nBITS=16, 0xFFFF + 0x0001 and cin=0 SHALL give sum=0x0000 and cout=1, with out_valid rising 4 edges after the accept.
REQ-031 With nBITS=16, 0x1234 + 0x4321 and cin=1 SHALL give sum=0x5556 and cout=0.
REQ-032 With out_ready held 0 for 10 cycles in DONE, sum and cout SHALL stay constant, and in_valid pulses during that window SHALL not be accepted.
REQ-033 With rst_n pulsed low at k=2 of ADD, all outputs SHALL be 0, in_ready SHALL be 1, and the next request SHALL complete correctly.
REQ-034 Two back-to-back requests with in_valid and out_ready held high SHALL complete with a 1-cycle IDLE gap, both results correct.
REQ-035 With CLA_SERIAL_OVF_EN defined, 0x7FFF + 0x0001 SHALL give ovf=1 and sum=0x8000, and 0xFFFF + 0x0001 SHALL give ovf=0.

Source files
------------

// File: rtl/cla_serial_ctrl_pkg.sv
// Shared types for the nibble-serial CLA adder.
// State encoding and slice width constant.
package cla_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/cla_serial_ctrl_slice.sv
// Combinational 4-bit carry lookahead adder slice.
// Carries are flattened generate/propagate sums.
module cla4_slice
  import cla_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              ci,
  output logic [NIBBLE-1:0] s,
  output logic              co
);

  logic [NIBBLE-1:0] g;
  logic [NIBBLE-1:0] p;
  logic [NIBBLE:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0])
              | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
  assign c[4] = g[3] | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);

  assign s  = p ^ c[NIBBLE-1:0];
  assign co = c[NIBBLE];

endmodule

// File: rtl/cla_serial_ctrl.sv
// Nibble-serial adder reusing one cla4_slice, LS nibble first.
// Optional signed overflow output: define CLA_SERIAL_OVF_EN.
module cla_serial_ctrl
  import cla_pkg::*;
#(
  parameter int nBITS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [nBITS-1:0] ain,
  input  logic [nBITS-1:0] bin,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [nBITS-1:0] sum,
  output logic             cout,
`ifdef CLA_SERIAL_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NSLICE = nBITS / NIBBLE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int MSB = nBITS - 1;

  if ((nBITS % NIBBLE) != 0 || nBITS < NIBBLE) begin : g_bad_width
    $error("cla_serial_ctrl: nBITS must be a multiple of 4, >= 4");
  end

  state_e            state_q, state_d;
  logic [KW-1:0]     k_q, k_d;
  logic              c_q, c_d;
  logic [nBITS-1:0]  a_q, a_d;
  logic [nBITS-1:0]  b_q, b_d;
  logic [nBITS-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
`ifdef CLA_SERIAL_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [NIBBLE-1:0] sl_a, sl_b, sl_s;
  logic              sl_co;
  logic              last;

  assign sl_a = a_q[NIBBLE*int'(k_q) +: NIBBLE];
  assign sl_b = b_q[NIBBLE*int'(k_q) +: NIBBLE];
  assign last = (k_q == KW'(NSLICE - 1));

  cla4_slice u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (c_q),
    .s  (sl_s),
    .co (sl_co)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef CLA_SERIAL_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = ain;
          b_d     = bin;
          c_d     = cin;
          k_d     = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        sum_d[NIBBLE*int'(k_q) +: NIBBLE] = sl_s;
        c_d = sl_co;
        k_d = k_q + KW'(1);
        if (last) begin
          cout_d  = sl_co;
          state_d = DONE;
`ifdef CLA_SERIAL_OVF_EN
          // Final slice holds the MSB, so its sum bit 3 is sum[MSB].
          ovf_d = (a_q[MSB] == b_q[MSB])
                && (sl_s[NIBBLE-1] != a_q[MSB]);
`endif
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef CLA_SERIAL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef CLA_SERIAL_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_cla_serial_ctrl.sv
// Self-checking bench for cla_serial_ctrl (nBITS=16).
// Reference results come from plain integer addition.
module tb_cla_serial_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] ain = '0;
  logic [W-1:0] bin = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef CLA_SERIAL_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cla_serial_ctrl #(.nBITS(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef CLA_SERIAL_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction; hold = cycles out_ready stays low in DONE.
  task automatic do_req(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic c,
                        input int hold);
    logic [W:0]   exp;
    logic [W-1:0] held_s;
    logic         held_c;
    int           lat;
    exp = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    @(negedge clk);
    check("idle_ready", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    ain       = a;
    bin       = b;
    cin       = c;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ain = W'($urandom);
    bin = W'($urandom);
    cin = 1'($urandom);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    check("ready_low_in_add", {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1)
        check("low_nibble_partial", {28'd0, sum[3:0]}, {28'd0, exp[3:0]});
      if (out_valid) break;
    end
    check("latency", lat, 4);
    check("sum", {16'd0, sum}, {16'd0, exp[W-1:0]});
    check("cout", {31'd0, cout}, {31'd0, exp[W]});
`ifdef CLA_SERIAL_OVF_EN
    check("ovf", {31'd0, ovf},
          {31'd0, (a[W-1] == b[W-1]) && (exp[W-1] != a[W-1])});
`endif
    held_s = sum;
    held_c = cout;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom);
      ain = W'($urandom);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_sum", {16'd0, sum}, {16'd0, held_s});
      check("hold_cout", {31'd0, cout}, {31'd0, held_c});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("back_idle", {30'd0, out_valid, in_ready}, 32'd1);
    check("retain_sum", {16'd0, sum}, {16'd0, exp[W-1:0]});
  endtask

  initial begin
    logic [W:0]   q_exp[$];
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   e;
    int issued, got, gap, cyc;

    #2;
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check("rst_outs", {13'd0, out_valid, busy, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_req(16'hFFFF, 16'h0001, 1'b0, 0);
    do_req(16'h1234, 16'h4321, 1'b1, 0);
    do_req(16'h7FFF, 16'h0001, 1'b0, 0);
    do_req(16'hA5A5, 16'h5A5A, 1'b1, 10);
    for (int i = 0; i < 8; i++)
      do_req(W'($urandom), W'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));

    // Abort mid-ADD at k=2.
    @(negedge clk);
    in_valid = 1'b1;
    ain = 16'h8888;
    bin = 16'h8888;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    check("abort_outs", {13'd0, out_valid, busy, cout, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_req(16'h0F0F, 16'h00F1, 1'b1, 0);

    // Back-to-back with in_valid and out_ready held high.
    issued = 0;
    got = 0;
    gap = 0;
    cyc = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    while (got < 2 && cyc < 40) begin
      cyc++;
      if (out_valid) begin
        e = q_exp.pop_front();
        check("b2b_sum", {16'd0, sum}, {16'd0, e[W-1:0]});
        check("b2b_cout", {31'd0, cout}, {31'd0, e[W]});
        got++;
      end else if (in_ready) begin
        if (got == 1) gap++;
        if (issued < 2) begin
          ra = W'($urandom);
          rb = W'($urandom);
          rc = 1'($urandom);
          ain = ra;
          bin = rb;
          cin = rc;
          q_exp.push_back({1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc});
          issued++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_results", got, 2);
    check("b2b_idle_gap", gap, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
